// File: rtl/uart_pkg.sv
// Shared UART types: read-arbiter FSM states, requester ids and the data width.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {RXA_IDLE, RXA_GRANT, RXA_SETTLE} rx_arb_state_t;
    typedef enum logic {RXA_CPU, RXA_DMA} rx_arb_src_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Receive-timeout counter: counts bit periods while data sits unread in the RX FIFO,
// raising a sticky interrupt when the count reaches TIMEOUT_BITS.
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic rCLK,
    input  logic rRST,
    input  logic bit_tick,
    input  logic fifo_rdata_valid,
    input  logic taken,
    input  logic rt_clr,
    output logic rx_timeout_irq
);

    logic [5:0] cnt;
    logic       hit;

    // Fires only on the tick that reaches the limit; a saturated count does not re-arm.
    assign hit = fifo_rdata_valid && !taken && bit_tick && (cnt == 6'(TIMEOUT_BITS - 1));

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            cnt <= '0;
        end else if (taken || !fifo_rdata_valid) begin
            cnt <= '0;
        end else if (bit_tick && (cnt != 6'(TIMEOUT_BITS))) begin
            cnt <= cnt + 6'd1;
        end
    end

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            rx_timeout_irq <= 1'b0;
        end else if (rt_clr || taken) begin
            rx_timeout_irq <= 1'b0;
        end else if (hit) begin
            rx_timeout_irq <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_read_arb.sv
// RX FIFO read-side controller: CPU/DMA read arbitration, pop pulse with settle time,
// level/timeout interrupts and DMA requests. DMA support is built only with UART_RX_DMA_EN.
module uart_rx_read_arb
    import uart_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 2,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                   rCLK,
    input  logic                   rRST,
    input  logic [UART_DATA_W-1:0] fifo_rdata,
    input  logic                   fifo_rdata_valid,
    input  logic                   fifo_alarm,
    output logic                   fifo_rdata_taken,
    input  logic                   cpu_rd_req,
    output logic                   cpu_rd_ack,
    output logic [UART_DATA_W-1:0] cpu_rd_data,
    input  logic                   dma_en,
    input  logic                   dma_rd_req,
    output logic                   dma_rd_ack,
    output logic [UART_DATA_W-1:0] dma_rd_data,
    output logic                   dma_sreq,
    output logic                   dma_breq,
    input  logic                   bit_tick,
    input  logic                   rt_clr,
    output logic                   rx_irq,
    output logic                   rx_timeout_irq
);

    localparam int unsigned SW = cnt_w(SETTLE_CYC);

    rx_arb_state_t state, state_nx;
    rx_arb_src_t   winner, winner_nx;
    logic [SW-1:0] settle_cnt, settle_cnt_nx;
    logic          cpu_pend;
    logic          dma_pend;

    assign cpu_pend = cpu_rd_req;

`ifdef UART_RX_DMA_EN
    rx_arb_src_t rr_last, rr_last_nx;

    // DMA is never granted on an empty FIFO, so its request only counts with data present.
    assign dma_pend = dma_en & dma_rd_req & fifo_rdata_valid;
    assign dma_sreq = dma_en & fifo_rdata_valid;
    assign dma_breq = dma_en & fifo_alarm;

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            rr_last <= RXA_DMA;
        end else begin
            rr_last <= rr_last_nx;
        end
    end
`else
    logic unused_dma;

    assign unused_dma = dma_en ^ dma_rd_req;
    assign dma_pend   = 1'b0;
    assign dma_sreq   = 1'b0;
    assign dma_breq   = 1'b0;
`endif

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            state      <= RXA_IDLE;
            winner     <= RXA_CPU;
            settle_cnt <= '0;
            rx_irq     <= 1'b0;
        end else begin
            state      <= state_nx;
            winner     <= winner_nx;
            settle_cnt <= settle_cnt_nx;
            rx_irq     <= fifo_alarm;
        end
    end

    always_comb begin
        state_nx         = state;
        winner_nx        = winner;
        settle_cnt_nx    = settle_cnt;
        cpu_rd_ack       = 1'b0;
        cpu_rd_data      = '0;
        dma_rd_ack       = 1'b0;
        dma_rd_data      = '0;
        fifo_rdata_taken = 1'b0;
`ifdef UART_RX_DMA_EN
        rr_last_nx       = rr_last;
`endif
        unique case (state)
            RXA_IDLE: begin
                if (cpu_pend || dma_pend) begin
                    state_nx = RXA_GRANT;
`ifdef UART_RX_DMA_EN
                    if (cpu_pend && dma_pend) begin
                        winner_nx = (rr_last == RXA_DMA) ? RXA_CPU : RXA_DMA;
                    end else begin
                        winner_nx = cpu_pend ? RXA_CPU : RXA_DMA;
                    end
`else
                    winner_nx = RXA_CPU;
`endif
                end
            end
            RXA_GRANT: begin
                // A request withdrawn before its ack cycle is dropped without a pop.
                state_nx      = RXA_IDLE;
                settle_cnt_nx = '0;
                if (winner == RXA_CPU) begin
                    if (cpu_rd_req) begin
                        cpu_rd_ack       = 1'b1;
                        cpu_rd_data      = fifo_rdata_valid ? fifo_rdata : '0;
                        fifo_rdata_taken = fifo_rdata_valid;
                        if (fifo_rdata_valid) begin
                            state_nx = RXA_SETTLE;
                        end
`ifdef UART_RX_DMA_EN
                        rr_last_nx = RXA_CPU;
`endif
                    end
                end
`ifdef UART_RX_DMA_EN
                else if (dma_rd_req && fifo_rdata_valid) begin
                    dma_rd_ack       = 1'b1;
                    dma_rd_data      = fifo_rdata;
                    fifo_rdata_taken = 1'b1;
                    state_nx         = RXA_SETTLE;
                    rr_last_nx       = RXA_DMA;
                end
`endif
            end
            RXA_SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    state_nx = RXA_IDLE;
                end else begin
                    settle_cnt_nx = settle_cnt + 1'b1;
                end
            end
            default: state_nx = RXA_IDLE;
        endcase
    end

    uart_rx_timeout #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_timeout (
        .rCLK            (rCLK),
        .rRST            (rRST),
        .bit_tick        (bit_tick),
        .fifo_rdata_valid(fifo_rdata_valid),
        .taken           (fifo_rdata_taken),
        .rt_clr          (rt_clr),
        .rx_timeout_irq  (rx_timeout_irq)
    );

endmodule

// File: tb/tb_uart_rx_read_arb.sv
// Scoreboard bench for uart_rx_read_arb with a behavioural RX FIFO; DMA cases need UART_RX_DMA_EN.
`timescale 1ns/1ps
module tb_uart_rx_read_arb;
    import uart_pkg::*;

    localparam int unsigned SETTLE_CYC   = 2;
    localparam int unsigned TIMEOUT_BITS = 32;
    localparam int unsigned ALARM_LVL    = 2;

    logic       rCLK = 1'b0;
    logic       rRST = 1'b1;
    logic [7:0] fifo_rdata;
    logic       fifo_rdata_valid;
    logic       fifo_alarm;
    logic       fifo_rdata_taken;
    logic       cpu_rd_req = 1'b0;
    logic       cpu_rd_ack;
    logic [7:0] cpu_rd_data;
    logic       dma_en = 1'b0;
    logic       dma_rd_req = 1'b0;
    logic       dma_rd_ack;
    logic [7:0] dma_rd_data;
    logic       dma_sreq;
    logic       dma_breq;
    logic       bit_tick = 1'b0;
    logic       rt_clr = 1'b0;
    logic       rx_irq;
    logic       rx_timeout_irq;

    always #5 rCLK = ~rCLK;

    uart_rx_read_arb #(
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_dut (
        .rCLK            (rCLK),
        .rRST            (rRST),
        .fifo_rdata      (fifo_rdata),
        .fifo_rdata_valid(fifo_rdata_valid),
        .fifo_alarm      (fifo_alarm),
        .fifo_rdata_taken(fifo_rdata_taken),
        .cpu_rd_req      (cpu_rd_req),
        .cpu_rd_ack      (cpu_rd_ack),
        .cpu_rd_data     (cpu_rd_data),
        .dma_en          (dma_en),
        .dma_rd_req      (dma_rd_req),
        .dma_rd_ack      (dma_rd_ack),
        .dma_rd_data     (dma_rd_data),
        .dma_sreq        (dma_sreq),
        .dma_breq        (dma_breq),
        .bit_tick        (bit_tick),
        .rt_clr          (rt_clr),
        .rx_irq          (rx_irq),
        .rx_timeout_irq  (rx_timeout_irq)
    );

    // Behavioural FIFO: pops on taken, pushes/flushes on bench request.
    logic [7:0]  mem [16] = '{default: 8'h00};
    logic [3:0]  rd_p = '0;
    logic [3:0]  wr_p = '0;
    logic [3:0]  level;
    logic        push_en = 1'b0;
    logic [7:0]  push_dat = '0;
    logic        flush = 1'b0;
    int unsigned taken_cnt = 0;
    int unsigned cyc = 0;

    assign level            = wr_p - rd_p;
    assign fifo_rdata       = mem[rd_p];
    assign fifo_rdata_valid = (level != 4'd0);
    assign fifo_alarm       = (level >= 4'(ALARM_LVL));

    always @(posedge rCLK) begin
        cyc <= cyc + 1;
        if (fifo_rdata_taken) begin
            rd_p      <= rd_p + 4'd1;
            taken_cnt <= taken_cnt + 1;
        end else if (flush) begin
            rd_p <= wr_p;
        end
        if (push_en) begin
            mem[wr_p] <= push_dat;
            wr_p      <= wr_p + 4'd1;
        end
    end

    typedef struct packed {
        rx_arb_src_t src;
        logic [7:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    rx_arb_src_t mon_src;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned last_ack_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation.
    always @(negedge rCLK) begin
        if (cpu_rd_ack || dma_rd_ack) begin
            last_ack_cyc = cyc;
            if (cpu_rd_ack && dma_rd_ack) begin
                chk("single_ack", 32'(cpu_rd_ack) + 32'(dma_rd_ack), 32'd1);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_src = cpu_rd_ack ? RXA_CPU : RXA_DMA;
                chk("ack_src", 32'(mon_src), 32'(mon_e.src));
                chk("ack_data", 32'(cpu_rd_ack ? cpu_rd_data : dma_rd_data), 32'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge rCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        push_dat = d;
        push_en  = 1'b1;
        step();
        push_en  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic expect_rd(input rx_arb_src_t s, input logic [7:0] d);
        exp_t e;
        e.src  = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Raises req and returns at the negedge of the ack cycle (req still high).
    task automatic cpu_req_until_ack(output int unsigned n);
        n = 0;
        cpu_rd_req = 1'b1;
        do begin
            @(negedge rCLK);
            n++;
        end while (!cpu_rd_ack && n < 40);
        if (!cpu_rd_ack) chk("cpu_ack_timeout", 32'(cpu_rd_ack), 32'd1);
    endtask

    task automatic cpu_read(output int unsigned n);
        cpu_req_until_ack(n);
        step();
        cpu_rd_req = 1'b0;
        step();
    endtask

`ifdef UART_RX_DMA_EN
    task automatic dma_req_until_ack(output int unsigned n);
        n = 0;
        dma_rd_req = 1'b1;
        do begin
            @(negedge rCLK);
            n++;
        end while (!dma_rd_ack && n < 40);
        if (!dma_rd_ack) chk("dma_ack_timeout", 32'(dma_rd_ack), 32'd1);
    endtask

    task automatic dma_read(output int unsigned n);
        dma_req_until_ack(n);
        step();
        dma_rd_req = 1'b0;
        step();
    endtask
`endif

    task automatic ticks(input int unsigned k);
        for (int unsigned i = 0; i < k; i++) begin
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned a1;
        int unsigned t0;

        // Reset state
        #3;
        chk("reset_outputs", 32'({fifo_rdata_taken, cpu_rd_ack, cpu_rd_data, dma_rd_ack,
                                  dma_rd_data, dma_sreq, dma_breq, rx_irq, rx_timeout_irq}), 32'd0);
        step();
        step();
        rRST = 1'b0;
        step();

        // 1: two pops, latency and spacing
        push(8'hA5);
        push(8'h3C);
        step();
        chk("rx_irq_level", 32'(rx_irq), 32'd1);
        t0 = taken_cnt;
        expect_rd(RXA_CPU, 8'hA5);
        cpu_read(n);
        chk("cpu_latency", n, 32'd2);
        chk("taken_first", taken_cnt - t0, 32'd1);
        a1 = last_ack_cyc;
        expect_rd(RXA_CPU, 8'h3C);
        cpu_read(n);
        chk("pop_spacing_ok", 32'((last_ack_cyc - a1) >= 2 + SETTLE_CYC), 32'd1);
        chk("taken_second", taken_cnt - t0, 32'd2);

        // 2: empty FIFO read
        t0 = taken_cnt;
        expect_rd(RXA_CPU, 8'h00);
        cpu_req_until_ack(n);
        step();
        cpu_rd_req = 1'b0;
        chk("empty_back_idle", 32'(u_dut.state), 32'(RXA_IDLE));
        step();
        chk("empty_no_taken", taken_cnt - t0, 32'd0);

        // 4: receive timeout
        push(8'h5A);
        ticks(TIMEOUT_BITS - 1);
        chk("timeout_before", 32'(rx_timeout_irq), 32'd0);
        ticks(1);
        chk("timeout_set", 32'(rx_timeout_irq), 32'd1);
        rt_clr = 1'b1;
        step();
        rt_clr = 1'b0;
        chk("timeout_rtclr", 32'(rx_timeout_irq), 32'd0);
        do_flush();
        push(8'h66);
        ticks(TIMEOUT_BITS - 1);
        bit_tick = 1'b1;
        rt_clr   = 1'b1;
        step();
        bit_tick = 1'b0;
        rt_clr   = 1'b0;
        step();
        step();
        chk("timeout_clr_wins", 32'(rx_timeout_irq), 32'd0);
        do_flush();
        push(8'h77);
        ticks(TIMEOUT_BITS);
        chk("timeout_set2", 32'(rx_timeout_irq), 32'd1);
        expect_rd(RXA_CPU, 8'h77);
        cpu_read(n);
        chk("timeout_taken_clr", 32'(rx_timeout_irq), 32'd0);

        // 5: async reset mid-SETTLE, then mid-GRANT
        push(8'h11);
        push(8'h22);
        push(8'h33);
        expect_rd(RXA_CPU, 8'h11);
        cpu_req_until_ack(n);
        step();
        cpu_rd_req = 1'b0;
        bit_tick   = 1'b1;
        step();
        bit_tick   = 1'b0;
        chk("pre_reset_cnt", 32'(u_dut.u_timeout.cnt), 32'd1);
        #1;
        rRST = 1'b1;
        #1;
        chk("settle_reset_outputs", 32'({fifo_rdata_taken, cpu_rd_ack, cpu_rd_data, dma_rd_ack,
                                         dma_rd_data, rx_irq, rx_timeout_irq}), 32'd0);
        chk("settle_reset_state", 32'(u_dut.state), 32'(RXA_IDLE));
        chk("settle_reset_cnt", 32'(u_dut.u_timeout.cnt), 32'd0);
        step();
        rRST = 1'b0;
        do_flush();
        push(8'h44);
        t0 = taken_cnt;
        expect_rd(RXA_CPU, 8'h44);
        cpu_req_until_ack(n);
        #1;
        rRST       = 1'b1;
        cpu_rd_req = 1'b0;
        #1;
        chk("grant_reset_taken", 32'({fifo_rdata_taken, cpu_rd_ack}), 32'd0);
        step();
        chk("grant_reset_no_pop", taken_cnt - t0, 32'd0);
        rRST = 1'b0;
        do_flush();

`ifdef UART_RX_DMA_EN
        // 3: round robin with both requesters held
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        dma_en = 1'b1;
        #1;
        chk("dma_sreq_breq", 32'({dma_sreq, dma_breq}), 32'h3);
        expect_rd(RXA_CPU, 8'h11);
        expect_rd(RXA_DMA, 8'h22);
        expect_rd(RXA_CPU, 8'h33);
        expect_rd(RXA_DMA, 8'h44);
        t0 = taken_cnt;
        fork
            begin
                int unsigned nc;
                cpu_read(nc);
                cpu_read(nc);
            end
            begin
                int unsigned nd;
                dma_read(nd);
                dma_read(nd);
            end
        join
        chk("rr_taken4", taken_cnt - t0, 32'd4);
        chk("dma_sreq_empty", 32'(dma_sreq), 32'd0);

        // dma_en drops during SETTLE: pop stands, no further grant
        push(8'hC1);
        push(8'hC2);
        t0 = taken_cnt;
        expect_rd(RXA_DMA, 8'hC1);
        dma_req_until_ack(n);
        step();
        dma_en = 1'b0;
        repeat (8) step();
        chk("dma_en_drop_taken", taken_cnt - t0, 32'd1);
        dma_rd_req = 1'b0;
        step();
        do_flush();
`else
        // 6: DMA inputs ignored without DMA support
        push(8'h9C);
        push(8'h9D);
        dma_en     = 1'b1;
        dma_rd_req = 1'b1;
        expect_rd(RXA_CPU, 8'h9C);
        fork
            begin
                int unsigned nc;
                cpu_read(nc);
                chk("nodma_cpu_latency", nc, 32'd2);
            end
            begin
                for (int unsigned i = 0; i < 6; i++) begin
                    @(negedge rCLK);
                    chk("nodma_outputs", 32'({dma_rd_ack, dma_rd_data, dma_sreq, dma_breq}), 32'd0);
                end
            end
        join
        dma_en     = 1'b0;
        dma_rd_req = 1'b0;
        do_flush();
`endif

        step();
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
